// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: upstream (in_*) and downstream (out_*) sides.
// The stage register uses the slave modport; the traffic source/sink uses master.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 12
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;

   modport master (
      output in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, synchronous flush
// and a saturating stall-cycle counter. All outputs come from registers (out_ctrl is gated by out_valid).
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             stat_clr_i,
   pipe_stage_reg_if.slave  bus,
   output logic [1:0]       occupancy_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] main_data_q;
   logic [CTRL_W-1:0] main_ctrl_q;
   logic [DATA_W-1:0] skid_data_q;
   logic [CTRL_W-1:0] skid_ctrl_q;
   logic              out_valid_q;
   logic              in_ready_q;
   logic [CNT_W-1:0]  stall_q;
   logic [CNT_W-1:0]  stall_d;
   logic              in_fire_s;
   logic              out_fire_s;

   assign in_fire_s  = bus.in_valid & in_ready_q;
   assign out_fire_s = out_valid_q & bus.out_ready;

   // Occupancy FSM: main register feeds the outputs, skid catches the transfer in flight when FULL is entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else if (flush_i) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  main_data_q <= bus.in_data;
                  main_ctrl_q <= bus.in_ctrl;
                  state_q     <= ST_BUSY;
                  out_valid_q <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (in_fire_s && out_fire_s) begin
                  main_data_q <= bus.in_data;
                  main_ctrl_q <= bus.in_ctrl;
               end else if (in_fire_s) begin
                  skid_data_q <= bus.in_data;
                  skid_ctrl_q <= bus.in_ctrl;
                  state_q     <= ST_FULL;
                  in_ready_q  <= 1'b0;
               end else if (out_fire_s) begin
                  state_q     <= ST_EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            ST_FULL: begin
               if (out_fire_s) begin
                  main_data_q <= skid_data_q;
                  main_ctrl_q <= skid_ctrl_q;
                  state_q     <= ST_BUSY;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   // Stall counter next state: clear wins, otherwise count stalled cycles up to all-ones.
   always_comb begin
      stall_d = stall_q;
      if (stat_clr_i) begin
         stall_d = '0;
      end else if (out_valid_q && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_d = stall_q;
      end
   end

   // Stall counter register; flush intentionally leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_data_q;
   assign bus.out_ctrl  = out_valid_q ? main_ctrl_q : {CTRL_W{1'b0}};
   assign occupancy_o   = state_q;
   assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, corner-case sequences,
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0, stat_clr = 1'b0;
   logic flush2 = 1'b0, stat_clr2 = 1'b0;
   logic [1:0]  occ, occ2;
   logic [15:0] stall;
   logic [3:0]  stall2;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(12)) b1 ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(12)) b2 ();

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(12), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .stat_clr_i(stat_clr),
      .bus(b1.slave), .occupancy_o(occ), .stall_cnt_o(stall)
   );

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(12), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush_i(flush2), .stat_clr_i(stat_clr2),
      .bus(b2.slave), .occupancy_o(occ2), .stall_cnt_o(stall2)
   );

   typedef struct {
      logic        iv, ordy, fl, sclr;
      logic [31:0] d;
      logic [11:0] c;
      logic [1:0]  occ;
      logic        ov, ir;
      logic [31:0] od;
      logic [11:0] oc;
      logic [15:0] st;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic [11:0] c;
   } entry_t;

   vec_t   vecs[18];
   entry_t mq[$];
   entry_t m_last;
   int     m_stall;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] e_occ, input logic e_ov, input logic e_ir,
                          input logic [31:0] e_od, input logic [11:0] e_oc, input logic [15:0] e_st);
      chk({tag, " occupancy"}, 64'(occ), 64'(e_occ));
      chk({tag, " out_valid"}, 64'(b1.out_valid), 64'(e_ov));
      chk({tag, " in_ready"},  64'(b1.in_ready), 64'(e_ir));
      chk({tag, " out_data"},  64'(b1.out_data), 64'(e_od));
      chk({tag, " out_ctrl"},  64'(b1.out_ctrl), 64'(e_oc));
      chk({tag, " stall_cnt"}, 64'(stall), 64'(e_st));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the stage is a FIFO of depth 2; the head is what is shown downstream.
   task automatic model_edge(input logic iv, input logic ordy, input logic fl, input logic sclr,
                             input entry_t e);
      bit inf, outf;
      inf  = iv && (mq.size() < 2);
      outf = (mq.size() > 0) && ordy;
      if (sclr) m_stall = 0;
      else if ((mq.size() > 0) && !ordy && (m_stall < 65535)) m_stall++;
      if (fl) begin
         mq.delete();
      end else begin
         if (outf) void'(mq.pop_front());
         if (inf) mq.push_back(e);
      end
      if (mq.size() > 0) m_last = mq[0];
   endtask

   task automatic drive1(input logic iv, input logic ordy, input logic fl, input logic sclr,
                         input logic [31:0] d, input logic [11:0] c);
      b1.in_valid = iv; b1.out_ready = ordy; flush = fl; stat_clr = sclr;
      b1.in_data = d; b1.in_ctrl = c;
   endtask

   initial begin
      entry_t e;
      logic [11:0] m_ctrl;
      drive1(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 12'hFFF);
      b2.in_valid = 1'b0; b2.out_ready = 1'b1; b2.in_data = 32'h0; b2.in_ctrl = 12'h0;

      // Reset state while rst_n is held low with live inputs
      repeat (3) step();
      chk_all("reset", 2'd0, 1'b0, 1'b1, 32'h0, 12'h0, 16'd0);
      chk("reset sat stall", 64'(stall2), 64'd0);
      #2 rst_n = 1'b1;
      b1.in_valid = 1'b0;

      // Saturation on the CNT_W=4 instance
      b2.in_valid = 1'b1; b2.out_ready = 1'b0; b2.in_data = 32'h55; b2.in_ctrl = 12'h155;
      step();
      b2.in_valid = 1'b0;
      chk("sat occ", 64'(occ2), 64'd1);
      chk("sat stall0", 64'(stall2), 64'd0);
      repeat (10) step();
      chk("sat stall10", 64'(stall2), 64'd10);
      repeat (10) step();
      chk("sat stall20", 64'(stall2), 64'd15);
      chk("sat data", 64'(b2.out_data), 64'h55);
      stat_clr2 = 1'b1;
      step();
      stat_clr2 = 1'b0;
      chk("sat clr", 64'(stall2), 64'd0);
      b2.out_ready = 1'b1;
      step();
      chk("sat drain", 64'(occ2), 64'd0);

      // Directed vectors: iv, ordy, flush, stat_clr, data, ctrl -> occ, ov, ir, od, oc, stall
      vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,32'h11,12'h001, 2'd1,1'b1,1'b1,32'h11,12'h001,16'd0};
      vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,32'h22,12'h002, 2'd1,1'b1,1'b1,32'h22,12'h002,16'd0};
      vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,32'h33,12'h003, 2'd1,1'b1,1'b1,32'h33,12'h003,16'd0};
      vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,32'h0, 12'h000, 2'd0,1'b0,1'b1,32'h33,12'h000,16'd0};
      vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,32'h5A,12'hFFF, 2'd0,1'b0,1'b1,32'h33,12'h000,16'd0};
      vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,32'h0A,12'h00A, 2'd1,1'b1,1'b1,32'h0A,12'h00A,16'd0};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,32'h0B,12'h00B, 2'd2,1'b1,1'b0,32'h0A,12'h00A,16'd1};
      vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,32'h0D,12'h00D, 2'd2,1'b1,1'b0,32'h0A,12'h00A,16'd2};
      vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,32'h0, 12'h000, 2'd1,1'b1,1'b1,32'h0B,12'h00B,16'd2};
      vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,32'h0, 12'h000, 2'd0,1'b0,1'b1,32'h0B,12'h000,16'd2};
      vecs[10] = '{1'b1,1'b0,1'b0,1'b0,32'h01,12'h001, 2'd1,1'b1,1'b1,32'h01,12'h001,16'd2};
      vecs[11] = '{1'b1,1'b0,1'b0,1'b0,32'h02,12'h002, 2'd2,1'b1,1'b0,32'h01,12'h001,16'd3};
      vecs[12] = '{1'b1,1'b0,1'b1,1'b0,32'h0C,12'h00C, 2'd0,1'b0,1'b1,32'h01,12'h000,16'd4};
      vecs[13] = '{1'b0,1'b1,1'b0,1'b0,32'h0, 12'h000, 2'd0,1'b0,1'b1,32'h01,12'h000,16'd4};
      vecs[14] = '{1'b0,1'b1,1'b0,1'b1,32'h0, 12'h000, 2'd0,1'b0,1'b1,32'h01,12'h000,16'd0};
      vecs[15] = '{1'b1,1'b1,1'b1,1'b0,32'h0E,12'h00E, 2'd0,1'b0,1'b1,32'h01,12'h000,16'd0};
      vecs[16] = '{1'b1,1'b1,1'b0,1'b0,32'h0F,12'h00F, 2'd1,1'b1,1'b1,32'h0F,12'h00F,16'd0};
      vecs[17] = '{1'b0,1'b1,1'b1,1'b0,32'h0, 12'h000, 2'd0,1'b0,1'b1,32'h0F,12'h000,16'd0};
      for (int i = 0; i < 18; i++) begin
         drive1(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].sclr, vecs[i].d, vecs[i].c);
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].occ, vecs[i].ov, vecs[i].ir,
                 vecs[i].od, vecs[i].oc, vecs[i].st);
      end

      // Randomized traffic against the FIFO model
      mq.delete();
      m_last = '{d: vecs[17].od, c: 12'h0};
      m_stall = int'(vecs[17].st);
      for (int i = 0; i < 400; i++) begin
         e.d = $urandom;
         e.c = 12'($urandom);
         drive1(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 29) == 0), e.d, e.c);
         model_edge(b1.in_valid, b1.out_ready, flush, stat_clr, e);
         step();
         m_ctrl = (mq.size() > 0) ? mq[0].c : 12'h0;
         chk_all($sformatf("rnd%0d", i), 2'(mq.size()), (mq.size() > 0), (mq.size() < 2),
                 (mq.size() > 0) ? mq[0].d : m_last.d, m_ctrl, 16'(m_stall));
      end

      // Async reset while FULL, asserted between edges
      drive1(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 12'h0);
      step();
      drive1(1'b1, 1'b0, 1'b0, 1'b0, 32'hA1, 12'h0A1);
      step();
      b1.in_data = 32'hA2; b1.in_ctrl = 12'h0A2;
      step();
      chk("pre-reset occ", 64'(occ), 64'd2);
      #3 rst_n = 1'b0;
      #1;
      chk_all("async rst", 2'd0, 1'b0, 1'b1, 32'h0, 12'h0, 16'd0);
      step();
      #2 rst_n = 1'b1;
      drive1(1'b1, 1'b1, 1'b0, 1'b0, 32'h77, 12'h077);
      step();
      chk_all("post rst", 2'd1, 1'b1, 1'b1, 32'h77, 12'h077, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
